mmio_csr_bank: RTL and testbench
================================

Name: mmio_csr_bank

Overview:
- Parametrised CCI-P MMIO register bank, successor to the fixed AFU-header read responder.
- Decodes MMIO read and write requests. Serves the DFH, the AFU ID, a scratch register, a cycle counter, a sticky event register and NUM_USER_CSRS writable 64-bit user registers.
- Supports both 4B and 8B accesses.
- Read latency is programmable.
- Sits between the buffered CCI-P c0 RX channel and the c2 TX channel of the AFU top.

Parameters:
- AFU_ID, 128'h0, AFU UUID returned at 0x0002/0x0004.
- DFH_NEXT_OFFSET, 24'h0, next-DFH offset field of the DFH.
- DFH_EOL, 1, end-of-list bit of the DFH.
- NUM_USER_CSRS, 8, number of user registers (1..64).
- USER_BASE, 16'h0020, dword address of user register 0. Must be even and must not overlap 0x0000-0x000F.
- NUM_EVT, 16, number of sticky event bits (1..64).
- RD_LATENCY, 1, cycles from request to response (1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mmio_rd_valid  in  1  MMIO read request strobe.
- mmio_wr_valid  in  1  MMIO write request strobe.
- mmio_addr  in  16  dword address.
- mmio_len  in  2  access size: 0 = 4B, 1 = 8B, other values = 8B.
- mmio_tid  in  9  read transaction ID.
- mmio_wr_data  in  64  write data.
- evt_in  in  NUM_EVT  event set pulses.
- rd_rsp_valid  out  1  read response strobe (c2 mmioRdValid).
- rd_rsp_tid  out  9  echoed TID.
- rd_rsp_data  out  64  response data.
- user_csr  out  64*NUM_USER_CSRS  user register contents, flat; register i is at [64i+63:64i].
- user_csr_wr  out  NUM_USER_CSRS  one-cycle pulse per written user register.

Behaviour:
- Reset (rst_n low, asynchronous): the following all clear to 0.
  - rd_rsp_valid, rd_rsp_tid, rd_rsp_data.
  - user_csr, user_csr_wr.
  - scratch, cycle counter, sticky events.
  - Read pipeline.
  - In-flight reads are dropped and never answered. The first request after deassertion is handled normally.
- Address map (dword addresses; 64-bit registers sit at even addresses):
  - 0x0000: DFH RO = {4'b0001, 8'b0, 4'b0, 7'b0, DFH_EOL, DFH_NEXT_OFFSET, 4'b0, 12'b0}.
  - 0x0002: AFU_ID[63:0] RO.
  - 0x0004: AFU_ID[127:64] RO.
  - 0x0006 and 0x0008: reserved, read 0.
  - 0x000A: scratch RW.
  - 0x000C: cycle counter RO. 64-bit, increments every cycle, wraps from all-ones to 0.
  - 0x000E: sticky events, zero-extended to 64 bits.
    - Bit i is set on evt_in[i].
    - A write clears every bit where wr_data is 1 (W1C).
    - If set and clear hit the same bit in the same cycle, set wins.
  - USER_BASE + 2*i: user register i, RW.
  - All other addresses: read 0, writes ignored.
- Read path:
  - One request accepted per cycle with no stall.
  - The request is decoded and the data captured at the request edge; data then shifts through RD_LATENCY-1 further stages.
  - rd_rsp_valid is high exactly RD_LATENCY cycles after mmio_rd_valid, carrying the matching TID.
  - Back-to-back requests produce back-to-back responses in order.
  - rd_rsp_data and rd_rsp_tid hold their last value when rd_rsp_valid is low.
  - The cycle counter read returns its value at the request edge.
- Access size:
  - 8B at an even address: full register.
  - 8B at an odd address: reads 0, write ignored.
  - 4B read: returns {32'h0, reg[31:0]} at an even address, {32'h0, reg[63:32]} at an odd address. The odd address decodes to register addr & ~1.
  - 4B write: updates only the addressed half, using wr_data[31:0]. For the W1C register, only the addressed half's clear bits apply.
- Writes:
  - Take effect at the request edge; the new value is visible on user_csr the next cycle.
  - user_csr_wr[i] pulses one cycle, coincident with the new user_csr value. This applies to 4B writes too.
  - Writes to RO or unmapped addresses: no effect, no pulse.
- Simultaneous read and write (possible at this interface):
  - Both are performed.
  - A read of the register being written returns the pre-write value.

Test Plan:
- Reset, then read 0x0000 (8B, tid 9'h05), RD_LATENCY=1, DFH_EOL=1 -> one cycle later rd_rsp_valid=1, tid 9'h05, data 64'h1000_0100_0000_0000. Reads of 0x0002/0x0004 return AFU_ID halves; read of 0x0008 returns 0.
- 8B write 64'hDEAD_BEEF_CAFE_F00D to 0x000A; then 4B write 32'h1234_5678 to 0x000B -> 8B read returns 64'h1234_5678_CAFE_F00D; 4B read of 0x000A returns 64'h0000_0000_CAFE_F00D.
- RD_LATENCY=3, reads on 4 consecutive cycles with tids 1..4 -> rd_rsp_valid high 3 cycles after each request, contiguous, tids 1,2,3,4 in order. Assert rst_n low mid-burst -> no further responses.
- Write 64'h5 to USER_BASE+2 (user register 1) -> user_csr[127:64]=5 and user_csr_wr=2'b10 for exactly one cycle. Same-cycle read of that address returns the old value 0. 8B write to USER_BASE+3 -> no change, no pulse.
- Pulse evt_in[3] and evt_in[0]; read 0x000E -> 64'h9. Write 64'h8 while evt_in[3] pulses again -> bit 3 stays set. Write 64'h9 with no events -> reads 0.
- Read 0x000C twice, N cycles apart -> difference equals N. Force the counter to all-ones -> next cycle reads 0.

Source files
------------

// File: rtl/mmio_csr_bank.sv
// -----------------------------------------------------------------------------
// mmio_csr_bank
//
// CCI-P MMIO register bank. Decodes MMIO reads and writes from the buffered c0
// RX channel and answers reads on the c2 TX channel after a fixed, parameterised
// latency. Serves the DFH, the AFU ID, a scratch register, a free-running cycle
// counter, a sticky event register and NUM_USER_CSRS writable user registers.
// Both 4B and 8B accesses are supported.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   mmio_rd_valid    read request strobe (one request per cycle, never stalled)
//   mmio_wr_valid    write request strobe
//   mmio_addr        dword address
//   mmio_len         0 = 4B, any other value = 8B
//   mmio_tid         read transaction ID, echoed on the response
//   mmio_wr_data     write data (4B writes use [31:0])
//   evt_in           event set pulses for the sticky event register
//   rd_rsp_valid     read response strobe
//   rd_rsp_tid       echoed TID
//   rd_rsp_data      response data
//   user_csr         user registers, flat; register i at [64i+63:64i]
//   user_csr_wr      one-cycle pulse per written user register
//
// Handshake: valid-only, no back-pressure. A request is taken on every rising
// edge where its strobe is high. rd_rsp_valid rises exactly RD_LATENCY cycles
// after the request, in request order; rd_rsp_tid/rd_rsp_data hold their last
// value while rd_rsp_valid is low.
// -----------------------------------------------------------------------------
module mmio_csr_bank #(
   parameter logic [127:0] AFU_ID          = 128'h0,
   parameter logic [23:0]  DFH_NEXT_OFFSET = 24'h0,
   parameter bit           DFH_EOL         = 1'b1,
   parameter int           NUM_USER_CSRS   = 8,
   parameter logic [15:0]  USER_BASE       = 16'h0020,
   parameter int           NUM_EVT         = 16,
   parameter int           RD_LATENCY      = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mmio_rd_valid,
   input  logic                         mmio_wr_valid,
   input  logic [15:0]                  mmio_addr,
   input  logic [1:0]                   mmio_len,
   input  logic [8:0]                   mmio_tid,
   input  logic [63:0]                  mmio_wr_data,
   input  logic [NUM_EVT-1:0]           evt_in,
   output logic                         rd_rsp_valid,
   output logic [8:0]                   rd_rsp_tid,
   output logic [63:0]                  rd_rsp_data,
   output logic [64*NUM_USER_CSRS-1:0]  user_csr,
   output logic [NUM_USER_CSRS-1:0]     user_csr_wr
);

   localparam int IDX_W = (NUM_USER_CSRS > 1) ? $clog2(NUM_USER_CSRS) : 1;

   localparam logic [63:0] DFH_VALUE = {4'b0001, 8'b0, 4'b0, 7'b0, DFH_EOL,
                                        DFH_NEXT_OFFSET, 4'b0, 12'b0};

   // Architectural state
   logic [63:0]              scratch_q, scratch_d;
   logic [63:0]              cycle_q;
   logic [NUM_EVT-1:0]       evt_q, evt_d, evt_clr;
   logic [63:0]              user_q [NUM_USER_CSRS];
   logic [63:0]              user_d [NUM_USER_CSRS];
   logic [NUM_USER_CSRS-1:0] user_wr_q, user_wr_d;

   // Read pipeline; stage RD_LATENCY-1 drives the response port
   logic                     pipe_vld_q  [RD_LATENCY];
   logic [8:0]               pipe_tid_q  [RD_LATENCY];
   logic [63:0]              pipe_data_q [RD_LATENCY];

   // Decode
   logic                     len_8b;
   logic [15:0]              reg_addr;
   logic [14:0]              user_slot;
   logic                     user_hit;
   logic [IDX_W-1:0]         user_idx;
   logic [63:0]              reg_rd_full;
   logic [63:0]              rd_word;
   logic                     wr_ok;
   logic [63:0]              wr_mask;
   logic [63:0]              wr_word;

   assign len_8b    = (mmio_len != 2'd0);
   // An odd address selects the upper half of the 64-bit register below it.
   assign reg_addr  = {mmio_addr[15:1], 1'b0};
   // User registers are decoded in 64-bit slot units (dword address / 2).
   assign user_slot = mmio_addr[15:1] - USER_BASE[15:1];
   assign user_hit  = (mmio_addr[15:1] >= USER_BASE[15:1]) &&
                      (user_slot < 15'(NUM_USER_CSRS));
   assign user_idx  = user_slot[IDX_W-1:0];

   // Full 64-bit value of the addressed register, pre-write state.
   always_comb begin
      reg_rd_full = '0;
      case (reg_addr)
         16'h0000: reg_rd_full = DFH_VALUE;
         16'h0002: reg_rd_full = AFU_ID[63:0];
         16'h0004: reg_rd_full = AFU_ID[127:64];
         16'h000A: reg_rd_full = scratch_q;
         16'h000C: reg_rd_full = cycle_q;
         16'h000E: reg_rd_full = 64'(evt_q);
         default:  reg_rd_full = '0;
      endcase
      if (user_hit) begin
         reg_rd_full = user_q[user_idx];
      end
   end

   // 8B at an odd address is not a legal alignment and reads as zero.
   assign rd_word = len_8b ? (mmio_addr[0] ? 64'h0 : reg_rd_full)
                           : {32'h0, (mmio_addr[0] ? reg_rd_full[63:32]
                                                   : reg_rd_full[31:0])};

   // Writes: 4B data is replicated to both halves and the lane mask picks one.
   assign wr_ok   = mmio_wr_valid && !(len_8b && mmio_addr[0]);
   assign wr_mask = len_8b ? {64{1'b1}}
                           : (mmio_addr[0] ? {{32{1'b1}}, 32'h0}
                                           : {32'h0, {32{1'b1}}});
   assign wr_word = len_8b ? mmio_wr_data : {2{mmio_wr_data[31:0]}};

   always_comb begin
      scratch_d = scratch_q;
      evt_clr   = '0;
      user_d    = user_q;
      user_wr_d = '0;
      if (wr_ok) begin
         if (reg_addr == 16'h000A) begin
            scratch_d = (scratch_q & ~wr_mask) | (wr_word & wr_mask);
         end
         if (reg_addr == 16'h000E) begin
            evt_clr = NUM_EVT'(wr_word & wr_mask);
         end
         if (user_hit) begin
            user_d[user_idx]    = (user_q[user_idx] & ~wr_mask) | (wr_word & wr_mask);
            user_wr_d[user_idx] = 1'b1;
         end
      end
      // Set is applied after clear so a same-cycle event wins over W1C.
      evt_d = (evt_q & ~evt_clr) | evt_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scratch_q <= '0;
         cycle_q   <= '0;
         evt_q     <= '0;
         user_wr_q <= '0;
         for (int i = 0; i < NUM_USER_CSRS; i++) begin
            user_q[i] <= '0;
         end
         for (int s = 0; s < RD_LATENCY; s++) begin
            pipe_vld_q[s]  <= 1'b0;
            pipe_tid_q[s]  <= '0;
            pipe_data_q[s] <= '0;
         end
      end else begin
         scratch_q <= scratch_d;
         cycle_q   <= cycle_q + 64'd1;
         evt_q     <= evt_d;
         user_wr_q <= user_wr_d;
         for (int i = 0; i < NUM_USER_CSRS; i++) begin
            user_q[i] <= user_d[i];
         end
         // Data/TID only advance with a valid entry so the port holds its last value.
         pipe_vld_q[0] <= mmio_rd_valid;
         if (mmio_rd_valid) begin
            pipe_tid_q[0]  <= mmio_tid;
            pipe_data_q[0] <= rd_word;
         end
         for (int s = 1; s < RD_LATENCY; s++) begin
            pipe_vld_q[s] <= pipe_vld_q[s-1];
            if (pipe_vld_q[s-1]) begin
               pipe_tid_q[s]  <= pipe_tid_q[s-1];
               pipe_data_q[s] <= pipe_data_q[s-1];
            end
         end
      end
   end

   assign rd_rsp_valid = pipe_vld_q[RD_LATENCY-1];
   assign rd_rsp_tid   = pipe_tid_q[RD_LATENCY-1];
   assign rd_rsp_data  = pipe_data_q[RD_LATENCY-1];
   assign user_csr_wr  = user_wr_q;

   always_comb begin
      user_csr = '0;
      for (int i = 0; i < NUM_USER_CSRS; i++) begin
         user_csr[64*i +: 64] = user_q[i];
      end
   end

endmodule

// File: tb/tb_mmio_csr_bank.sv
// -----------------------------------------------------------------------------
// tb_mmio_csr_bank
//
// Self-checking bench for mmio_csr_bank. A directed vector table with
// hand-computed read data, a few hand-written multi-cycle sequences (read burst,
// reset mid-burst, counter wrap) and a randomised phase, all checked against a
// register-map model and a response scoreboard kept in the bench.
// -----------------------------------------------------------------------------
module tb_mmio_csr_bank;

   localparam int            LAT     = 3;
   localparam int            NU      = 8;
   localparam int            NE      = 16;
   localparam logic [15:0]   UB      = 16'h0020;
   localparam logic [127:0]  AFU     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [63:0]   DFH_EXP = 64'h1000_0100_0000_0000;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                mmio_rd_valid = 1'b0;
   logic                mmio_wr_valid = 1'b0;
   logic [15:0]         mmio_addr     = '0;
   logic [1:0]          mmio_len      = '0;
   logic [8:0]          mmio_tid      = '0;
   logic [63:0]         mmio_wr_data  = '0;
   logic [NE-1:0]       evt_in        = '0;
   logic                rd_rsp_valid;
   logic [8:0]          rd_rsp_tid;
   logic [63:0]         rd_rsp_data;
   logic [64*NU-1:0]    user_csr;
   logic [NU-1:0]       user_csr_wr;

   mmio_csr_bank #(
      .AFU_ID          (AFU),
      .DFH_NEXT_OFFSET (24'h0),
      .DFH_EOL         (1'b1),
      .NUM_USER_CSRS   (NU),
      .USER_BASE       (UB),
      .NUM_EVT         (NE),
      .RD_LATENCY      (LAT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mmio_rd_valid (mmio_rd_valid),
      .mmio_wr_valid (mmio_wr_valid),
      .mmio_addr     (mmio_addr),
      .mmio_len      (mmio_len),
      .mmio_tid      (mmio_tid),
      .mmio_wr_data  (mmio_wr_data),
      .evt_in        (evt_in),
      .rd_rsp_valid  (rd_rsp_valid),
      .rd_rsp_tid    (rd_rsp_tid),
      .rd_rsp_data   (rd_rsp_data),
      .user_csr      (user_csr),
      .user_csr_wr   (user_csr_wr)
   );

   // ---------------- vector record ----------------
   typedef struct {
      logic          rd;
      logic          wr;
      logic [15:0]   addr;
      logic [1:0]    len;
      logic [8:0]    tid;
      logic [63:0]   wdata;
      logic [NE-1:0] evt;
      logic          use_exp;   // read data checked against exp instead of the model
      logic [63:0]   exp;
   } vec_t;

   function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [1:0] len, input logic [8:0] tid,
                               input logic [63:0] wdata, input logic [NE-1:0] evt,
                               input logic use_exp, input logic [63:0] exp);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.len = len; v.tid = tid;
      v.wdata = wdata; v.evt = evt; v.use_exp = use_exp; v.exp = exp;
      return v;
   endfunction

   function automatic vec_t idle_vec();
      return mk(1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0, '0, 1'b0, 64'h0);
   endfunction

   // ---------------- reference model ----------------
   logic [63:0] m_scratch;
   logic [63:0] m_cycle;
   logic [63:0] m_evt;
   logic [63:0] m_user [NU];
   logic [NU-1:0] exp_wr;

   function automatic logic [63:0] m_reg(input logic [15:0] base);
      int k;
      if (base >= UB && base < UB + 16'(2*NU)) begin
         k = int'(base - UB) / 2;
         return m_user[k];
      end
      case (base)
         16'h0000: return DFH_EXP;
         16'h0002: return AFU[63:0];
         16'h0004: return AFU[127:64];
         16'h000A: return m_scratch;
         16'h000C: return m_cycle;
         16'h000E: return m_evt;
         default:  return 64'h0;
      endcase
   endfunction

   function automatic logic [63:0] m_read(input logic [15:0] addr, input logic [1:0] len);
      logic [63:0] full;
      full = m_reg({addr[15:1], 1'b0});
      if (len != 2'd0) return addr[0] ? 64'h0 : full;
      return addr[0] ? {32'h0, full[63:32]} : {32'h0, full[31:0]};
   endfunction

   task automatic m_write(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] wd);
      logic [15:0] base;
      logic [63:0] cur, nv, clr;
      int k;
      base = {addr[15:1], 1'b0};
      if (len != 2'd0 && addr[0]) return;
      cur = m_reg(base);
      if (len != 2'd0) begin
         nv  = wd;
         clr = wd;
      end else if (addr[0]) begin
         nv  = {wd[31:0], cur[31:0]};
         clr = {wd[31:0], 32'h0};
      end else begin
         nv  = {cur[63:32], wd[31:0]};
         clr = {32'h0, wd[31:0]};
      end
      if (base >= UB && base < UB + 16'(2*NU)) begin
         k = int'(base - UB) / 2;
         m_user[k] = nv;
         exp_wr[k] = 1'b1;
      end else if (base == 16'h000A) begin
         m_scratch = nv;
      end else if (base == 16'h000E) begin
         m_evt = m_evt & ~clr;
      end
   endtask

   task automatic m_reset();
      m_scratch = '0;
      m_cycle   = '0;
      m_evt     = '0;
      exp_wr    = '0;
      for (int i = 0; i < NU; i++) m_user[i] = '0;
   endtask

   // ---------------- scoreboard ----------------
   logic [72:0] exp_q[$];   // {tid, data}
   int          due_q[$];   // cycle index at which each response must appear
   int          cyc;
   logic [8:0]  last_tid;
   logic [63:0] last_data;
   int          chk_cnt  = 0;
   int          pass_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check_outputs();
      logic [72:0] e;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         e = exp_q.pop_front();
         void'(due_q.pop_front());
         check("rsp_valid", 64'(rd_rsp_valid), 64'd1);
         check("rsp_tid", 64'(rd_rsp_tid), 64'(e[72:64]));
         check("rsp_data", rd_rsp_data, e[63:0]);
         last_tid  = e[72:64];
         last_data = e[63:0];
      end else begin
         check("rsp_idle", 64'(rd_rsp_valid), 64'd0);
         check("rsp_tid_hold", 64'(rd_rsp_tid), 64'(last_tid));
         check("rsp_data_hold", rd_rsp_data, last_data);
      end
      for (int i = 0; i < NU; i++) check("user_csr", user_csr[64*i +: 64], m_user[i]);
      check("user_csr_wr", 64'(user_csr_wr), 64'(exp_wr));
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge: drives one request cycle, advances the
   // model by one rising edge, then checks outputs at the next falling edge.
   task automatic tick(input vec_t v);
      logic [63:0] rdat;
      mmio_rd_valid = v.rd;
      mmio_wr_valid = v.wr;
      mmio_addr     = v.addr;
      mmio_len      = v.len;
      mmio_tid      = v.tid;
      mmio_wr_data  = v.wdata;
      evt_in        = v.evt;
      exp_wr = '0;
      if (v.rd) begin
         rdat = v.use_exp ? v.exp : m_read(v.addr, v.len);
         exp_q.push_back({v.tid, rdat});
         due_q.push_back(cyc + LAT);
      end
      if (v.wr) m_write(v.addr, v.len, v.wdata);
      m_evt   = m_evt | 64'(v.evt);
      m_cycle = m_cycle + 64'd1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      mmio_rd_valid = 1'b0;
      mmio_wr_valid = 1'b0;
      evt_in        = '0;
      check_outputs();
   endtask

   task automatic rd(input logic [15:0] a, input logic [1:0] len, input logic [8:0] tid);
      tick(mk(1'b1, 1'b0, a, len, tid, 64'h0, '0, 1'b0, 64'h0));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(idle_vec());
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      m_reset();
      exp_q.delete();
      due_q.delete();
      last_tid  = '0;
      last_data = '0;
      #1;
      check("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
      check("rst_rsp_tid", 64'(rd_rsp_tid), 64'd0);
      check("rst_rsp_data", rd_rsp_data, 64'd0);
      check("rst_user_csr", user_csr[63:0], 64'd0);
      check("rst_user_csr_wr", 64'(user_csr_wr), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   // ---------------- test ----------------
   vec_t tbl[$];

   initial begin
      vec_t v;
      cyc = 0;
      m_reset();
      last_tid  = '0;
      last_data = '0;

      // Directed table: {rd, wr, addr, len, tid, wdata, evt, use_exp, exp}
      tbl.push_back(mk(1, 0, 16'h0000, 2'd1, 9'h05, 64'h0, '0, 1, DFH_EXP));
      tbl.push_back(mk(1, 0, 16'h0002, 2'd1, 9'h06, 64'h0, '0, 1, 64'hFEDC_BA98_7654_3210));
      tbl.push_back(mk(1, 0, 16'h0004, 2'd1, 9'h07, 64'h0, '0, 1, 64'h0123_4567_89AB_CDEF));
      tbl.push_back(mk(1, 0, 16'h0008, 2'd1, 9'h08, 64'h0, '0, 1, 64'h0));
      tbl.push_back(mk(0, 1, 16'h000A, 2'd1, 9'h00, 64'hDEAD_BEEF_CAFE_F00D, '0, 0, 64'h0));
      tbl.push_back(mk(0, 1, 16'h000B, 2'd0, 9'h00, 64'hFFFF_FFFF_1234_5678, '0, 0, 64'h0));
      tbl.push_back(mk(1, 0, 16'h000A, 2'd1, 9'h09, 64'h0, '0, 1, 64'h1234_5678_CAFE_F00D));
      tbl.push_back(mk(1, 0, 16'h000A, 2'd0, 9'h0A, 64'h0, '0, 1, 64'h0000_0000_CAFE_F00D));
      tbl.push_back(mk(1, 0, 16'h000B, 2'd0, 9'h0B, 64'h0, '0, 1, 64'h0000_0000_1234_5678));
      tbl.push_back(mk(1, 1, 16'h0022, 2'd1, 9'h0C, 64'h5, '0, 1, 64'h0));
      tbl.push_back(mk(1, 0, 16'h0022, 2'd1, 9'h0D, 64'h0, '0, 1, 64'h5));
      tbl.push_back(mk(0, 1, 16'h0023, 2'd1, 9'h00, 64'hFFFF_FFFF_FFFF_FFFF, '0, 0, 64'h0));
      tbl.push_back(mk(1, 0, 16'h0023, 2'd1, 9'h0E, 64'h0, '0, 1, 64'h0));
      tbl.push_back(mk(1, 0, 16'h0022, 2'd1, 9'h0F, 64'h0, '0, 1, 64'h5));
      tbl.push_back(mk(0, 1, 16'h0025, 2'd0, 9'h00, 64'h0000_0000_AAAA_5555, '0, 0, 64'h0));
      tbl.push_back(mk(1, 0, 16'h0024, 2'd1, 9'h10, 64'h0, '0, 1, 64'hAAAA_5555_0000_0000));
      tbl.push_back(mk(0, 0, 16'h0000, 2'd0, 9'h00, 64'h0, 16'h0009, 0, 64'h0));
      tbl.push_back(mk(1, 0, 16'h000E, 2'd1, 9'h11, 64'h0, '0, 1, 64'h9));
      tbl.push_back(mk(0, 1, 16'h000E, 2'd1, 9'h00, 64'h8, 16'h0008, 0, 64'h0));
      tbl.push_back(mk(1, 0, 16'h000E, 2'd1, 9'h12, 64'h0, '0, 1, 64'h9));
      tbl.push_back(mk(0, 1, 16'h000E, 2'd1, 9'h00, 64'h9, '0, 0, 64'h0));
      tbl.push_back(mk(1, 0, 16'h000E, 2'd1, 9'h13, 64'h0, '0, 1, 64'h0));
      tbl.push_back(mk(0, 1, 16'h0002, 2'd1, 9'h00, 64'h1111_2222_3333_4444, '0, 0, 64'h0));
      tbl.push_back(mk(1, 0, 16'h0002, 2'd1, 9'h14, 64'h0, '0, 1, 64'hFEDC_BA98_7654_3210));
      tbl.push_back(mk(0, 1, 16'h0040, 2'd1, 9'h00, 64'h7777, '0, 0, 64'h0));
      tbl.push_back(mk(1, 0, 16'h0040, 2'd1, 9'h15, 64'h0, '0, 1, 64'h0));
      tbl.push_back(mk(1, 0, 16'h0005, 2'd0, 9'h16, 64'h0, '0, 1, 64'h0000_0000_0123_4567));

      apply_reset();
      check("post_rst_valid", 64'(rd_rsp_valid), 64'd0);

      foreach (tbl[i]) tick(tbl[i]);
      idle(LAT);

      // Back-to-back burst: responses contiguous and in TID order
      for (int t = 1; t <= 4; t++) rd(16'h000A, 2'd1, 9'(t));
      idle(LAT);

      // Reset mid-burst: the two reads still in flight are never answered
      for (int t = 1; t <= 4; t++) rd(16'h0022, 2'd1, 9'(t + 32));
      apply_reset();
      idle(LAT + 3);

      // Cycle counter: two reads 7 cycles apart, then wrap from all-ones
      rd(16'h000C, 2'd1, 9'h40);
      idle(6);
      rd(16'h000C, 2'd1, 9'h41);
      idle(LAT);
      force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.cycle_q;
      m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
      tick(mk(1, 0, 16'h000C, 2'd1, 9'h42, 64'h0, '0, 1, 64'hFFFF_FFFF_FFFF_FFFF));
      tick(mk(1, 0, 16'h000C, 2'd1, 9'h43, 64'h0, '0, 1, 64'h0));
      rd(16'h000D, 2'd0, 9'h44);
      idle(LAT);

      // Randomised traffic against the model
      for (int n = 0; n < 600; n++) begin
         v = idle_vec();
         v.rd    = ($urandom_range(0, 99) < 50);
         v.wr    = ($urandom_range(0, 99) < 40);
         v.len   = 2'($urandom_range(0, 3));
         v.tid   = 9'($urandom_range(0, 511));
         v.wdata = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: v.addr = 16'($urandom_range(0, 17));
            1: v.addr = UB + 16'($urandom_range(0, 2*NU + 1));
            2: v.addr = 16'($urandom_range(0, 65535));
            default: v.addr = 16'h000E + 16'($urandom_range(0, 1));
         endcase
         if ($urandom_range(0, 3) == 0) v.evt = NE'($urandom);
         tick(v);
      end
      idle(LAT + 1);
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
